// File: rtl/keypad_event_ctrl.sv
// Scans a 4x5 active-low keypad, debounces whole frames and queues
// press/release events in a small FIFO drained over valid/ready.
module keypad_event_ctrl #(
    parameter int SETTLE_CYC      = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [4:0]  key_row,
    output logic [3:0]  key_col,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [5:0]  ev_code,
    output logic [19:0] key_state,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DEB_MAX     = CW'(DEBOUNCE_FRAMES);
    localparam logic [AW:0]   FIFO_FULL   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        COMPARE,
        EMIT
    } state_t;

    state_t        state;
    logic [1:0]    col_idx;
    logic [SW-1:0] settle_cnt;
    logic [19:0]   frame;
    logic [19:0]   cand;
    logic [CW-1:0] stable_cnt;

    logic [5:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;

    logic [19:0]   cand_next;
    logic [CW-1:0] cnt_next;
    logic [19:0]   diff;
    logic [19:0]   low_onehot;
    logic [19:0]   remaining;
    logic [4:0]    low_idx;
    logic          push;
    logic          pop;
    logic          full;
    logic          do_push;

    function automatic logic [4:0] lowest_index(input logic [19:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 19; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    // A new frame restarts the stable count; a repeated one saturates it.
    always_comb begin
        cand_next = cand;
        cnt_next  = stable_cnt;
        if (frame == cand) begin
            if (stable_cnt < DEB_MAX) cnt_next = stable_cnt + 1'b1;
        end else begin
            cand_next = frame;
            cnt_next  = CW'(1);
        end
    end

    assign diff       = cand ^ key_state;
    assign low_onehot = diff & (~diff + 20'd1);
    assign remaining  = diff & ~low_onehot;
    assign low_idx    = lowest_index(diff);

    assign push     = (state == EMIT) && (diff != '0);
    assign ev_valid = (fifo_count != '0);
    assign pop      = ev_valid && ev_ready;
    assign full     = (fifo_count == FIFO_FULL);
    assign do_push  = push && (!full || pop);
    assign ev_code  = ev_valid ? fifo_mem[rd_ptr] : 6'd0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            col_idx    <= '0;
            settle_cnt <= '0;
            frame      <= '0;
            cand       <= '0;
            stable_cnt <= '0;
            key_state  <= '0;
            key_col    <= 4'b1111;
        end else begin
            case (state)
                IDLE: begin
                    state      <= SETTLE;
                    col_idx    <= '0;
                    settle_cnt <= '0;
                    key_col    <= 4'b1110;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    frame[col_idx*5 +: 5] <= ~key_row;
                    if (col_idx != 2'd3) begin
                        col_idx    <= col_idx + 2'd1;
                        settle_cnt <= '0;
                        key_col    <= ~(4'b0001 << (col_idx + 2'd1));
                        state      <= SETTLE;
                    end else begin
                        key_col <= 4'b1111;
                        state   <= COMPARE;
                    end
                end
                COMPARE: begin
                    cand       <= cand_next;
                    stable_cnt <= cnt_next;
                    if (cnt_next >= DEB_MAX && cand_next != key_state) begin
                        state <= EMIT;
                    end else begin
                        col_idx    <= '0;
                        settle_cnt <= '0;
                        key_col    <= 4'b1110;
                        state      <= SETTLE;
                    end
                end
                EMIT: begin
                    // key_state follows even when the event itself is dropped
                    key_state <= key_state ^ low_onehot;
                    if (remaining == '0) begin
                        col_idx    <= '0;
                        settle_cnt <= '0;
                        key_col    <= 4'b1110;
                        state      <= SETTLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    key_col <= 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf        <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= {cand[low_idx], low_idx};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!do_push && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (push && !do_push) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed bench for keypad_event_ctrl driven by a behavioural keypad model.
module tb_keypad_event_ctrl;

    logic        clk;
    logic        rstn;
    logic [4:0]  key_row;
    logic [3:0]  key_col;
    logic        ev_valid;
    logic        ev_ready;
    logic [5:0]  ev_code;
    logic [19:0] key_state;
    logic        ovf;
    logic        ovf_clr;

    logic [19:0] held;
    int          tests_run;
    int          tests_failed;

    keypad_event_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_row   (key_row),
        .key_col   (key_col),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .key_state (key_state),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A row reads low when any held key on it sits in a driven column.
    always_comb begin
        key_row = 5'b11111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 5; r++) begin
                if (held[c*5 + r] && !key_col[c]) key_row[r] = 1'b0;
            end
        end
    end

    task automatic wait_compare();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_col == 4'b1111) return;
        end
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL wait_compare: key_col never returned to 1111 within 60 cycles");
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (ev_valid) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        rstn     = 1'b0;
        held     = '0;
        ev_ready = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (key_col !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL reset_key_col: got %b expected 1111", key_col);
        end
        tests_run++;
        if (ev_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ev_valid: got %b expected 0", ev_valid);
        end
        tests_run++;
        if (key_state !== 20'h0 || ovf !== 1'b0 || ev_code !== 6'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: key_state %h ovf %b ev_code %h expected 0", key_state, ovf, ev_code);
        end
        rstn = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (i <= 5)       exp_col = 4'b1110;
            else if (i <= 10) exp_col = 4'b1101;
            else if (i <= 15) exp_col = 4'b1011;
            else if (i <= 20) exp_col = 4'b0111;
            else              exp_col = 4'b1111;
            tests_run++;
            if (key_col !== exp_col) begin
                tests_failed++;
                $display("[TB] FAIL scan_cycle_%0d: key_col %b expected %b", i, key_col, exp_col);
            end
        end
    endtask

    task automatic test_single_key();
        int n;
        logic seen;
        ev_ready = 1'b1;
        wait_compare();
        held[7] = 1'b1;
        wait_valid(n);
        tests_run++;
        if (n != 65 || ev_code !== 6'h27 || key_state !== 20'h00080) begin
            tests_failed++;
            $display("[TB] FAIL press_c1r2: latency %0d code %h state %h expected 65 27 00080", n, ev_code, key_state);
        end
        @(negedge clk);
        tests_run++;
        if (ev_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL press_popped: ev_valid %b expected 0", ev_valid);
        end
        seen = 1'b0;
        repeat (126) begin
            @(negedge clk);
            if (ev_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL held_no_repeat: extra event seen %b expected 0", seen);
        end
        wait_compare();
        held[7] = 1'b0;
        wait_valid(n);
        tests_run++;
        if (n != 65 || ev_code !== 6'h07 || key_state !== 20'h0) begin
            tests_failed++;
            $display("[TB] FAIL release_c1r2: latency %0d code %h state %h expected 65 07 00000", n, ev_code, key_state);
        end
    endtask

    task automatic test_bounce();
        logic seen;
        wait_compare();
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            held[0] = ~held[0];
            repeat (21) begin
                @(negedge clk);
                if (ev_valid) seen = 1'b1;
            end
        end
        repeat (100) begin
            @(negedge clk);
            if (ev_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0 || key_state !== 20'h0) begin
            tests_failed++;
            $display("[TB] FAIL bounce: event seen %b state %h expected 0 00000", seen, key_state);
        end
    endtask

    task automatic test_two_keys();
        int n;
        ev_ready = 1'b1;
        wait_compare();
        held[0]  = 1'b1;
        held[19] = 1'b1;
        wait_valid(n);
        tests_run++;
        if (n != 65 || ev_code !== 6'h20) begin
            tests_failed++;
            $display("[TB] FAIL two_keys_first: latency %0d code %h expected 65 20", n, ev_code);
        end
        @(negedge clk);
        tests_run++;
        if (ev_valid !== 1'b1 || ev_code !== 6'h33) begin
            tests_failed++;
            $display("[TB] FAIL two_keys_second: valid %b code %h expected 1 33", ev_valid, ev_code);
        end
        @(negedge clk);
        tests_run++;
        if (ev_valid !== 1'b0 || key_state !== 20'h80001) begin
            tests_failed++;
            $display("[TB] FAIL two_keys_done: valid %b state %h expected 0 80001", ev_valid, key_state);
        end
        wait_compare();
        held = '0;
        repeat (100) @(negedge clk);
        tests_run++;
        if (key_state !== 20'h0 || ev_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL two_keys_release: state %h valid %b expected 00000 0", key_state, ev_valid);
        end
    endtask

    task automatic test_overflow();
        int n;
        ev_ready = 1'b0;
        wait_compare();
        held[4:0] = 5'h1F;
        wait_valid(n);
        tests_run++;
        if (n != 65) begin
            tests_failed++;
            $display("[TB] FAIL ovf_latency: got %0d expected 65", n);
        end
        repeat (6) @(negedge clk);
        tests_run++;
        if (ovf !== 1'b1 || key_state !== 20'h0001F || ev_valid !== 1'b1 || ev_code !== 6'h20) begin
            tests_failed++;
            $display("[TB] FAIL ovf_set: ovf %b state %h valid %b code %h expected 1 0001f 1 20", ovf, key_state, ev_valid, ev_code);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_clear: ovf %b expected 0", ovf);
        end
        ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (ev_valid !== 1'b1 || ev_code !== 6'(6'h20 + k)) begin
                tests_failed++;
                $display("[TB] FAIL drain_%0d: valid %b code %h expected 1 %h", k, ev_valid, ev_code, 6'(6'h20 + k));
            end
            @(negedge clk);
        end
        tests_run++;
        if (ev_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drain_empty: valid %b expected 0", ev_valid);
        end
        wait_compare();
        held = '0;
        repeat (100) @(negedge clk);
        tests_run++;
        if (key_state !== 20'h0 || ev_valid !== 1'b0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ovf_release: state %h valid %b ovf %b expected 00000 0 0", key_state, ev_valid, ovf);
        end
    endtask

    task automatic test_reset_mid_emit();
        int n;
        ev_ready = 1'b0;
        wait_compare();
        held[0]  = 1'b1;
        held[19] = 1'b1;
        repeat (65) @(negedge clk);
        tests_run++;
        if (ev_valid !== 1'b1 || key_col !== 4'b1111 || key_state !== 20'h00001) begin
            tests_failed++;
            $display("[TB] FAIL mid_emit: valid %b col %b state %h expected 1 1111 00001", ev_valid, key_col, key_state);
        end
        rstn = 1'b0;
        #1;
        tests_run++;
        if (ev_valid !== 1'b0 || key_state !== 20'h0 || ev_code !== 6'h0 || key_col !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL abort_reset: valid %b state %h code %h col %b expected 0 00000 00 1111", ev_valid, key_state, ev_code, key_col);
        end
        @(negedge clk);
        rstn = 1'b1;
        wait_valid(n);
        tests_run++;
        if (n != 65 || ev_code !== 6'h20) begin
            tests_failed++;
            $display("[TB] FAIL reappear_first: latency %0d code %h expected 65 20", n, ev_code);
        end
        ev_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ev_valid !== 1'b1 || ev_code !== 6'h33) begin
            tests_failed++;
            $display("[TB] FAIL reappear_second: valid %b code %h expected 1 33", ev_valid, ev_code);
        end
        @(negedge clk);
        tests_run++;
        if (ev_valid !== 1'b0 || key_state !== 20'h80001) begin
            tests_failed++;
            $display("[TB] FAIL reappear_done: valid %b state %h expected 0 80001", ev_valid, key_state);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_key();
        test_bounce();
        test_two_keys();
        test_overflow();
        test_reset_mid_emit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
